// File: rtl/btn_pkg.sv
// Shared constants for the pushbutton debouncer: channel count, board button
// index map and default filter timing.
package btn_pkg;

    // Number of board pushbuttons handled by the debouncer.
    localparam int unsigned N_BTN = 5;

    // Bit positions of each board button in the debouncer vectors.
    localparam int unsigned BTN_C = 0;
    localparam int unsigned BTN_U = 1;
    localparam int unsigned BTN_L = 2;
    localparam int unsigned BTN_R = 3;
    localparam int unsigned BTN_D = 4;

    // Default filter timing: 2-flop synchronizer, 10 ms at 100 MHz.
    localparam int unsigned SYNC_STAGES_DEF     = 2;
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000000;

    // Width of a counter that has to hold 0 .. cycles-1.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debouncer channel: synchronizer chain, stability counter, accepted level
// and registered edge pulses. The release pulse exists only when
// BTN_RELEASE_PULSE_EN is defined.
module btn_debounce_ch #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic o_release
`endif
);

    import btn_pkg::*;

    localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   w_sync;
    logic                   w_differ;
    logic                   w_accept;

    // Synchronizer chain: raw pin enters bit 0, the top bit is the only safe sample.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_differ = w_sync ^ r_level;
    // Accept once the new level has been seen for DEBOUNCE_CYCLES edges in a row.
    assign w_accept = w_differ && (r_cnt == CNT_MAX);

    // Stability counter: runs only while the sample disagrees with the accepted level,
    // so any single-cycle return to the old level restarts it from zero.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (!w_differ || w_accept) begin
            r_cnt <= '0;
        end else if (r_cnt < CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Accepted level and press pulse update on the same edge, so the pulse marks
    // exactly the first cycle the level reads 1.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_press <= w_accept & w_sync;
            if (w_accept) begin
                r_level <= w_sync;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

`ifdef BTN_RELEASE_PULSE_EN
    logic r_release;

    // Release pulse: first cycle the level reads 0 after being 1; level resets to 0,
    // so this cannot fire straight out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_release <= 1'b0;
        end else begin
            r_release <= w_accept & ~w_sync;
        end
    end

    assign o_release = r_release;
`endif

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer for the memory-mapped I/O block. Each board button is
// synchronized and filtered independently; outputs are clean levels plus
// one-cycle press pulses. Define BTN_RELEASE_PULSE_EN to add the btn_release
// port with matching one-cycle release pulses.
module btn_debounce #(
    parameter int unsigned N_BTN           = btn_pkg::N_BTN,
    parameter int unsigned SYNC_STAGES     = btn_pkg::SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = btn_pkg::DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press
`ifdef BTN_RELEASE_PULSE_EN
    ,
    output logic [N_BTN-1:0] btn_release
`endif
);

    import btn_pkg::*;

    // Channels are fully independent; bit i of every vector belongs to channel i
    // (C, U, L, R, D at BTN_C .. BTN_D).
    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk     (clk),
            .i_rst_n   (rst_n),
            .i_raw     (btn_raw[g]),
            .o_level   (btn_level[g]),
            .o_press   (btn_press[g])
`ifdef BTN_RELEASE_PULSE_EN
            ,
            .o_release (btn_release[g])
`endif
        );
    end

endmodule

// File: doc/btn_debounce.md
Name: btn_debounce

Overview:
- Upstream input-conditioning stage for the memory-mapped I/O block.
- Takes raw, asynchronous board pushbuttons (C, U, L, R, D), synchronizes each to clk, and filters contact bounce.
- Outputs clean levels, which feed the button read registers, plus one-cycle press pulses for edge-triggered software polling.
- Inputs are processed as independent channels with no cross-channel interaction.

Parameters:
- N_BTN, 5, number of button channels; bit index order is C=0, U=1, L=2, R=3, D=4.
- SYNC_STAGES, 2, flip-flop depth of the synchronizer per channel; legal values >= 2.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz); legal values >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- btn_raw  input  N_BTN  raw asynchronous button pins.
- btn_level  output  N_BTN  debounced level; 1 = pressed.
- btn_press  output  N_BTN  one-cycle pulse on each debounced 0->1 transition.
- btn_release  output  N_BTN  one-cycle pulse on each debounced 1->0 transition; exists only with BTN_RELEASE_PULSE_EN.

Behaviour:
- Reset is synchronous and active-low, sampled on the rising edge of clk. While rst_n=0, all of the following are cleared to 0:
  - synchronizer flops
  - per-channel counters
  - btn_level, btn_press, btn_release
- After reset, every channel is treated as released.
- Synchronizer: each channel passes through a SYNC_STAGES-deep flop chain. The last stage is sync[i]. The raw input has no other path into the logic.
- Counter: one per channel, width $clog2(DEBOUNCE_CYCLES), unsigned.
  - If sync[i] == btn_level[i], the counter is set to 0.
  - If they differ and the counter < DEBOUNCE_CYCLES-1, the counter increments.
  - If they differ and the counter == DEBOUNCE_CYCLES-1, btn_level[i] toggles to sync[i] and the counter is set to 0 in the same edge.
  - The counter never wraps.
- Acceptance rule: a new level must be present on sync[i] for DEBOUNCE_CYCLES consecutive cycles. Any single-cycle return to the old level restarts the count from 0.
- Latency: a clean raw edge reaches btn_level after SYNC_STAGES + DEBOUNCE_CYCLES rising edges.
- btn_press[i] is registered. It is 1 exactly in the first cycle that btn_level[i] reads 1, and 0 otherwise.
- Holding a button does not retrigger btn_press; there is no auto-repeat.
- Simultaneous changes on several channels are handled independently, and pulses may coincide.
- If rst_n is asserted mid-count, the count is discarded. A button held through reset is re-accepted DEBOUNCE_CYCLES after sync[i] goes to 1, and produces a fresh btn_press.

Optional Feature:
- Macro: BTN_RELEASE_PULSE_EN.
- With the macro defined:
  - The btn_release port exists.
  - btn_release[i] is 1 exactly in the first cycle btn_level[i] reads 0 after having been 1.
  - btn_release resets to 0 and can never pulse directly out of reset.
- Without the macro: the port and its logic are absent, and all other behaviour is unchanged.

Decomposition:
- Package btn_pkg holds:
  - localparam N_BTN = 5
  - index constants BTN_C=0, BTN_U=1, BTN_L=2, BTN_R=3, BTN_D=4, used by the top level to map into the I/O block
- Sub-module btn_debounce_ch is one channel: synchronizer, counter, level, and pulse logic.
- btn_debounce instantiates N_BTN copies of btn_debounce_ch in a generate loop and concatenates their outputs.

Test Plan (DEBOUNCE_CYCLES=8, SYNC_STAGES=2):
- Reset: hold rst_n=0 for 3 cycles with btn_raw=5'b11111, then release -> all outputs are 0 during reset. Exactly 10 edges after release, btn_level=5'b11111 and btn_press=5'b11111 for one cycle.
- Clean press: btn_raw[0] rises and is held -> btn_level[0]=1 on edge 10, btn_press[0]=1 for exactly that cycle, and btn_press[0] stays 0 for the next 100 held cycles.
- Bounce: btn_raw[2] toggles 1,0,1,0 every 3 cycles, then holds 1 -> btn_level[2] stays 0 throughout the bounce. It rises 10 edges after the final 0->1 transition, with exactly one btn_press[2] pulse.
- Glitch rejection: btn_raw[3] is high for 7 cycles, then low -> btn_level[3] and btn_press[3] never assert.
- Simultaneous, independent channels: btn_raw[1] and btn_raw[4] rise together while btn_raw[0] is released -> bits 1 and 4 pulse in the same cycle; bit 0 drops 10 edges after its release.
- Reset mid-count: btn_raw[0]=1 with counter at 5, then rst_n=0 for 1 cycle -> btn_level[0] stays 0 and the count restarts. With BTN_RELEASE_PULSE_EN, btn_release pulses once, 10 edges after a press-then-release.
